muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_unit_div_iter.sv | 68 ++++++
 rtl/muldiv_unit.sv | 119 +++++++++++
 tb/tb_muldiv_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encoding and FSM state type for the multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } state_t;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Radix-2 restoring divider on operand magnitudes; the final step's result is
// sign-corrected combinationally so the top can capture it on the last edge.
module div_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             neg_quo_q, neg_rem_q;
    logic [CW-1:0]    cnt_q;

    logic             sign_a, sign_b, fits;
    logic [WIDTH-1:0] a_mag, b_mag, rem_n, quo_n;
    logic [WIDTH:0]   shifted, diff;

    always_comb begin
        sign_a  = is_signed & a[WIDTH-1];
        sign_b  = is_signed & b[WIDTH-1];
        a_mag   = sign_a ? -a : a;
        b_mag   = sign_b ? -b : b;
        // quo_q doubles as the dividend shift register: its MSB feeds the remainder.
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = ~diff[WIDTH];
        rem_n   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_n   = {quo_q[WIDTH-2:0], fits};
        quo     = neg_quo_q ? -quo_n : quo_n;
        rem     = neg_rem_q ? -rem_n : rem_n;
        last    = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
        end else if (load) begin
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            neg_quo_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            cnt_q     <= '0;
        end else if (step) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit: pipelined multiplier plus an iterative divider under one
// control FSM; hi/lo are written only when entering the done state.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PIPE_DEPTH = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;

    state_t             state_q;
    logic [1:0]         cnt_q;
    logic [2*WIDTH-1:0] pipe_q [PIPE_DEPTH];
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               accept, is_div, is_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod_now;
    logic               div_last;
    logic [WIDTH-1:0]   div_quo, div_rem;

    always_comb begin
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        accept    = start && (state_q == StIdle) && !cancel;
        // Low 2*WIDTH bits of the extended product are correct for both signednesses.
        ext_a     = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
        ext_b     = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
        prod_now  = ext_a * ext_b;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        hi        = hi_q;
        lo        = lo_q;
    end

    div_iter #(
        .WIDTH(WIDTH)
    ) u_div_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && is_div),
        .step     ((state_q == StDiv) && !cancel),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .last     (div_last),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            // The pipeline free-runs; only the sample taken at the accept edge is used.
            pipe_q[0] <= prod_now;
            for (int i = 1; i < PIPE_DEPTH; i++) pipe_q[i] <= pipe_q[i-1];

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (is_div) begin
                            if (b == '0) begin
                                state_q <= StDone;
                                hi_q    <= a;
                                lo_q    <= '1;
                            end else begin
                                state_q <= StDiv;
                            end
                        end else if (MUL_LATENCY == 1) begin
                            state_q      <= StDone;
                            {hi_q, lo_q} <= prod_now;
                        end else begin
                            state_q <= StMul;
                            cnt_q   <= '0;
                        end
                    end
                end
                StMul: begin
                    if (cancel) begin
                        state_q <= StIdle;
                    end else if (cnt_q == 2'(MUL_LATENCY - 2)) begin
                        state_q      <= StDone;
                        {hi_q, lo_q} <= pipe_q[PIPE_DEPTH-1];
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                StDiv: begin
                    if (cancel) begin
                        state_q <= StIdle;
                    end else if (div_last) begin
                        state_q <= StDone;
                        hi_q    <= div_rem;
                        lo_q    <= div_quo;
                    end
                end
                StDone: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32, MUL_LATENCY=3) against an arithmetic model.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam int L = 3;

    logic          clk = 1'b0;
    logic          rst, start, cancel;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  held_hi = '0;
    logic [W-1:0]  held_lo = '0;

    typedef struct {
        logic [1:0]   o;
        logic [W-1:0] x, y, h, l;
        int           lat;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_unit #(
        .WIDTH      (W),
        .MUL_LATENCY(L)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain-arithmetic reference: {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0:    return 64'(sx * sy);
            2'd1:    return {32'b0, x} * {32'b0, y};
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (o == 2'd2) return {32'(sx % sy), 32'(sx / sy)};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [W-1:0] y);
        if (o < 2) return L;
        return (y == 0) ? 1 : W + 1;
    endfunction

    // Drives an accept in cycle 0 and returns in cycle 1 with scrambled inputs.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom);
    endtask

    // Advances until done (bounded); reports cycle index, whether done was seen, and
    // whether busy stayed high with hi/lo untouched before it.
    task automatic run_to_done(input int n0, output int n, output bit seen, output bit held);
        n    = n0;
        seen = 1'b0;
        held = 1'b1;
        while (!seen && n <= W + 8) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1 || hi !== held_hi || lo !== held_lo) held = 1'b0;
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
        end
    endtask

    task automatic test_directed();
        vec_t v [8];
        int   n;
        bit   seen, held;
        v[0] = '{2'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 3};
        v[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3};
        v[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        v[3] = '{2'd3, 32'd100,       32'd7,        32'd2,         32'd14,        33};
        v[4] = '{2'd3, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1};
        v[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
        v[6] = '{2'd2, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
        v[7] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
        for (int i = 0; i < 8; i++) begin
            launch(v[i].o, v[i].x, v[i].y);
            run_to_done(1, n, seen, held);
            tests++;
            if (!seen || n != v[i].lat || hi !== v[i].h || lo !== v[i].l || !held) begin
                fails++;
                $display("FAIL directed[%0d]: done_seen=%0d cycle=%0d hi=%h lo=%h held=%0d, want cycle=%0d hi=%h lo=%h held=1",
                         i, seen, n, hi, lo, held, v[i].lat, v[i].h, v[i].l);
            end
            held_hi = v[i].h;
            held_lo = v[i].l;
            tick();
            tests++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL directed_after[%0d]: busy=%b done=%b, want 0 0", i, busy, done);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [W-1:0] x, y;
        logic [63:0] exp;
        int          n;
        bit          seen, held;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       y = '0;
                1:       y = '1;
                2:       y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            exp = model(o, x, y);
            launch(o, x, y);
            run_to_done(1, n, seen, held);
            tests++;
            if (!seen || n != latency(o, y) || {hi, lo} !== exp || !held) begin
                fails++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: done_seen=%0d cycle=%0d hi=%h lo=%h held=%0d, want cycle=%0d hi=%h lo=%h",
                         i, o, x, y, seen, n, hi, lo, held, latency(o, y), exp[63:32], exp[31:0]);
            end
            held_hi = exp[63:32];
            held_lo = exp[31:0];
            tick();
        end
    endtask

    task automatic test_ignore_start();
        logic [63:0] exp;
        int          n;
        bit          seen, held;
        exp = model(2'd2, 32'hFFFF_FC18, 32'd3);
        launch(2'd2, 32'hFFFF_FC18, 32'd3);
        repeat (4) tick();
        start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
        tick();
        start = 1'b0;
        run_to_done(6, n, seen, held);
        tests++;
        if (!seen || n != W + 1 || {hi, lo} !== exp) begin
            fails++;
            $display("FAIL ignore_start: done_seen=%0d cycle=%0d hi=%h lo=%h, want cycle=%0d hi=%h lo=%h",
                     seen, n, hi, lo, W + 1, exp[63:32], exp[31:0]);
        end
        held_hi = exp[63:32];
        held_lo = exp[31:0];
        tick();
    endtask

    task automatic test_cancel();
        int cyc [3] = '{10, 32, 2};
        bit got_done;
        for (int k = 0; k < 3; k++) begin
            launch((k == 2) ? 2'd0 : 2'd2, $urandom, 32'($urandom_range(1, 1000)));
            repeat (cyc[k] - 1) tick();
            cancel = 1'b1;
            tick();
            cancel = 1'b0;
            tests++;
            if (busy !== 1'b0 || done !== 1'b0 || hi !== held_hi || lo !== held_lo) begin
                fails++;
                $display("FAIL cancel[%0d]: busy=%b done=%b hi=%h lo=%h, want 0 0 hi=%h lo=%h",
                         k, busy, done, hi, lo, held_hi, held_lo);
            end
            got_done = 1'b0;
            repeat (40) begin
                if (done !== 1'b0) got_done = 1'b1;
                tick();
            end
            tests++;
            if (got_done) begin
                fails++;
                $display("FAIL cancel_no_done[%0d]: done pulse seen=1, want 0", k);
            end
        end
        start = 1'b1; cancel = 1'b1; op = 2'd1;
        tick();
        start = 1'b0; cancel = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL cancel_blocks_accept: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_cancel_at_done();
        logic [63:0] exp;
        int          n;
        bit          seen, held;
        exp = model(2'd1, 32'hDEAD_BEEF, 32'h1234_5678);
        launch(2'd1, 32'hDEAD_BEEF, 32'h1234_5678);
        run_to_done(1, n, seen, held);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tests++;
        if (!seen || n != L || busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== exp) begin
            fails++;
            $display("FAIL cancel_at_done: done_seen=%0d cycle=%0d busy=%b done=%b hi=%h lo=%h, want cycle=%0d busy=0 done=0 hi=%h lo=%h",
                     seen, n, busy, done, hi, lo, L, exp[63:32], exp[31:0]);
        end
        held_hi = exp[63:32];
        held_lo = exp[31:0];
    endtask

    task automatic test_reset_mid();
        bit got_done;
        launch(2'd0, 32'h1234_5678, 32'h0000_0100);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
        end
        held_hi = '0;
        held_lo = '0;
        got_done = 1'b0;
        repeat (10) begin
            if (done !== 1'b0) got_done = 1'b1;
            tick();
        end
        tests++;
        if (got_done) begin
            fails++;
            $display("FAIL reset_mid_no_done: done pulse seen=1, want 0");
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit seen, held;
        launch(2'd3, 32'd100, 32'd7);
        run_to_done(1, n, seen, held);
        tests++;
        if (!seen || hi !== 32'd2 || lo !== 32'd14) begin
            fails++;
            $display("FAIL b2b_first: done_seen=%0d hi=%h lo=%h, want hi=2 lo=14", seen, hi, lo);
        end
        held_hi = 32'd2;
        held_lo = 32'd14;
        start = 1'b1; op = 2'd0; a = 32'hFFFF_FFFD; b = 32'd5;
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_start_in_done: busy=%b, want 0", busy);
        end
        tick();
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b, want 1", busy);
        end
        run_to_done(1, n, seen, held);
        tests++;
        if (!seen || n != L || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1 || !held) begin
            fails++;
            $display("FAIL b2b_second: done_seen=%0d cycle=%0d hi=%h lo=%h held=%0d, want cycle=%0d hi=ffffffff lo=fffffff1",
                     seen, n, hi, lo, held, L);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_cancel();
        test_cancel_at_done();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
